// File: rtl/cpu_bus_mem_bridge_if.sv
// cpu_bus_mem_bridge_if: handler pin bundle; master = CPU handler, slave = memory bridge
//   bus_a_in  : address bytes, then the write flag in bit 0 (handler -> memory)
//   bus_d_in  : write-data bytes (handler -> memory)
//   bus_d_out : read-data byte (memory -> handler)
//   bus_d_oe  : high while the memory side drives bus_d_out
interface cpu_bus_mem_bridge_if;
  logic [7:0] bus_a_in;
  logic [7:0] bus_d_in;
  logic [7:0] bus_d_out;
  logic       bus_d_oe;
  modport master (output bus_a_in, bus_d_in, input bus_d_out, bus_d_oe);
  modport slave (input bus_a_in, bus_d_in, output bus_d_out, bus_d_oe);
endinterface

// File: rtl/cpu_bus_mem_bridge.sv
// cpu_bus_mem_bridge: memory endpoint of the 18-phase handler pin protocol with a side preload port
//   clk, rst  : shared clock, async active-high reset
//   bus       : handler pins (slave side)
//   ld_we/ld_idx/ld_data -> ld_ack : preload a RAM word while the frame is in phase 0
//   acc_done  : pulse after each frame access; acc_we: last access was a write
//   addr_err  : sticky out-of-range access flag
module cpu_bus_mem_bridge #(
  parameter int AW         = 4,
  parameter int FRAME_LAST = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_bus_mem_bridge_if.slave   bus,
  input  logic                  ld_we,
  input  logic [AW-1:0]         ld_idx,
  input  logic [63:0]           ld_data,
  output logic                  ld_ack,
  output logic                  acc_done,
  output logic                  acc_we,
  output logic                  addr_err
);
  localparam int PW = $clog2(FRAME_LAST + 1);
  logic [PW-1:0] phase_q, phase_d;
  logic [63:0]   addr_q, addr_d, wdata_q, wdata_d, rd_word_q, rd_word_d;
  logic [7:0]    dout_q, dout_d;
  logic          we_q, we_d, oe_q, oe_d, ld_ack_q, ld_ack_d;
  logic          acc_done_q, acc_done_d, acc_we_q, acc_we_d, addr_err_q, addr_err_d;
  logic [63:0]   mem [0:(1<<AW)-1];
  logic [2:0]    sel;
  logic          cap, ret, cur_we, in_q, in_d, ld_go, wr_go;
  // sel = phase-1 mod 8: byte lane for capture (phases 1..8) and for return (phases 9..16)
  always_comb begin
    sel        = phase_q[2:0] - 3'd1;
    cap        = phase_q >= PW'(1) && phase_q <= PW'(8);
    ret        = phase_q >= PW'(9) && phase_q <= PW'(16);
    phase_d    = (phase_q == PW'(FRAME_LAST)) ? '0 : phase_q + PW'(1);
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (cap) begin
      addr_d[{sel, 3'b000} +: 8]  = bus.bus_a_in;
      wdata_d[{sel, 3'b000} +: 8] = bus.bus_d_in;
    end
    in_q       = addr_q[63:AW+3] == '0;
    in_d       = addr_d[63:AW+3] == '0;
    rd_word_d  = (phase_q == PW'(8)) ? (in_d ? mem[addr_d[AW+2:3]] : '0) : rd_word_q;
    // the write flag is on the pins during phase 9 itself, so that edge uses it directly
    cur_we     = (phase_q == PW'(9)) ? bus.bus_a_in[0] : we_q;
    we_d       = cur_we;
    oe_d       = ret && !cur_we;
    dout_d     = oe_d ? rd_word_q[{sel, 3'b000} +: 8] : '0;
    ld_go      = phase_q == '0 && ld_we;
    wr_go      = phase_q == PW'(9) && bus.bus_a_in[0] && in_q;
    ld_ack_d   = ld_go;
    acc_done_d = phase_q == PW'(9);
    acc_we_d   = acc_done_d ? bus.bus_a_in[0] : acc_we_q;
    addr_err_d = addr_err_q | (acc_done_d && !in_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_word_q  <= '0;
      we_q       <= 1'b0;
      dout_q     <= '0;
      oe_q       <= 1'b0;
      ld_ack_q   <= 1'b0;
      acc_done_q <= 1'b0;
      acc_we_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_word_q  <= rd_word_d;
      we_q       <= we_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      ld_ack_q   <= ld_ack_d;
      acc_done_q <= acc_done_d;
      acc_we_q   <= acc_we_d;
      addr_err_q <= addr_err_d;
    end
  end
  // RAM keeps its contents through reset; preload (phase 0) and frame write (phase 9) are exclusive
  always_ff @(posedge clk) begin
    if (ld_go) mem[ld_idx] <= ld_data;
    else if (wr_go) mem[addr_q[AW+2:3]] <= wdata_q;
  end
  assign bus.bus_d_out = dout_q;
  assign bus.bus_d_oe  = oe_q;
  assign ld_ack        = ld_ack_q;
  assign acc_done      = acc_done_q;
  assign acc_we        = acc_we_q;
  assign addr_err      = addr_err_q;
endmodule

// File: tb/tb_cpu_bus_mem_bridge.sv
// tb_cpu_bus_mem_bridge: random frames and preloads checked against an array model of the RAM
module tb_cpu_bus_mem_bridge;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cpu_bus_mem_bridge_if bus ();
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_idx = '0;
  logic [63:0]   ld_data = '0;
  logic          ld_ack, acc_done, acc_we, addr_err;
  cpu_bus_mem_bridge #(.AW(AW), .FRAME_LAST(17)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ld_we(ld_we), .ld_idx(ld_idx),
    .ld_data(ld_data), .ld_ack(ld_ack), .acc_done(acc_done),
    .acc_we(acc_we), .addr_err(addr_err)
  );
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] mem_m [16];
  bit          err_m = 0, acc_we_m = 0, ack_exp = 0, ld_pend = 0;
  logic [3:0]  ld_i_m;
  logic [63:0] ld_d_m;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction
  // one whole frame starting at the negedge inside phase 0; optional preload request at phase ld_at
  // and optional reset at phase rst_at (frame abandoned, phase restarts at 0)
  task automatic frame(input logic [63:0] addr, input logic [63:0] wdata, input bit we,
                       input int ld_at = -1, input logic [3:0] li = '0,
                       input logic [63:0] ld = '0, input int rst_at = -1);
    bit          inr  = addr[63:AW+3] == '0;
    logic [3:0]  idx  = addr[AW+2:3];
    logic [63:0] word = '0;
    bit          rd;
    for (int p = 0; p < 18; p++) begin
      rd = p >= 10 && !we;
      chk("ld_ack", ld_ack, ack_exp);
      chk("acc_done", acc_done, p == 10);
      chk("bus_d_oe", bus.bus_d_oe, rd);
      chk("bus_d_out", bus.bus_d_out, rd ? (word >> (8 * (p - 10))) & 64'hff : 64'h0);
      chk("acc_we", acc_we, acc_we_m);
      chk("addr_err", addr_err, err_m);
      if (p == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_oe", bus.bus_d_oe, 0);
        chk("rst_out", bus.bus_d_out, 0);
        chk("rst_acc_we", acc_we, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_ld_ack", ld_ack, 0);
        chk("rst_acc_done", acc_done, 0);
        @(negedge clk);
        rst = 1'b0;
        err_m = 0;
        acc_we_m = 0;
        ack_exp = 0;
        return;
      end
      if (p == ld_at) begin
        ld_pend = 1;
        ld_i_m  = li;
        ld_d_m  = ld;
      end
      bus.bus_a_in = (p >= 1 && p <= 8) ? 8'(addr >> (8 * (p - 1))) :
                     (p == 9) ? {7'($urandom), we} : 8'($urandom);
      bus.bus_d_in = (p >= 1 && p <= 8) ? 8'(wdata >> (8 * (p - 1))) : 8'($urandom);
      ld_we   = ld_pend;
      ld_idx  = ld_pend ? ld_i_m : 4'($urandom);
      ld_data = ld_pend ? ld_d_m : rnd64();
      ack_exp = p == 0 && ld_pend;
      if (p == 0 && ld_pend) begin
        mem_m[ld_i_m] = ld_d_m;
        ld_pend = 0;
      end
      if (p == 8) word = inr ? mem_m[idx] : 64'h0;
      if (p == 9) begin
        if (!inr) err_m = 1;
        else if (we) mem_m[idx] = wdata;
        acc_we_m = we;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    logic [63:0] a;
    bus.bus_a_in = '0;
    bus.bus_d_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_oe", bus.bus_d_oe, 0);
    chk("reset_out", bus.bus_d_out, 0);
    chk("reset_ld_ack", ld_ack, 0);
    chk("reset_acc_done", acc_done, 0);
    chk("reset_acc_we", acc_we, 0);
    chk("reset_addr_err", addr_err, 0);
    rst = 1'b0;
    frame(64'h18, rnd64(), 0, 0, 4'd3, 64'h1122334455667788);
    for (int i = 0; i < 16; i++)
      if (i != 3) frame(64'h18, rnd64(), 0, 0, 4'(i), rnd64());
    frame(64'h28, 64'hDEADBEEF00C0FFEE, 1);
    frame(64'h28, rnd64(), 0);
    frame(64'h100, rnd64(), 1);
    frame(64'h100, rnd64(), 0);
    frame(64'h1D, rnd64(), 0);
    frame(64'h18, rnd64(), 0, 5, 4'd7, rnd64());
    frame(64'h38, rnd64(), 0);
    frame(64'h18, rnd64(), 0, -1, '0, '0, 12);
    frame(64'h18, rnd64(), 0);
    for (int n = 0; n < 40; n++) begin
      a = {57'h0, 4'($urandom), 3'($urandom)};
      if ($urandom_range(0, 7) == 0) a = a | (64'h1 << $urandom_range(7, 63));
      if (!ld_pend && $urandom_range(0, 3) == 0)
        frame(a, rnd64(), 1'($urandom), $urandom_range(0, 17), 4'($urandom), rnd64());
      else
        frame(a, rnd64(), 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
